// File: rtl/bullet_engine.sv
// bullet_engine: two independent bullet channels for a two-player shooter.
// Channel 0 belongs to player 1 and flies +x toward player 2.
// Channel 1 belongs to player 2 and flies -x toward player 1.
// Each channel cycles IDLE -> FLY -> COOL -> IDLE. A hit or miss is
// decided on the frame tick that reaches the far player's column, and a hit
// is reported as a registered one-cycle pulse.
module bullet_engine #(
    parameter int SCREEN_W = 640,
    parameter int P1_X     = 32,
    parameter int P2_X     = 608,
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 32,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 30
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       enable_i,
    input  logic       frame_tick_i,
    input  logic       fire_1_i,
    input  logic       fire_2_i,
    input  logic [9:0] player_1_y_i,
    input  logic [9:0] player_2_y_i,
    output logic [9:0] bullet_1_x_o,
    output logic [9:0] bullet_1_y_o,
    output logic [9:0] bullet_2_x_o,
    output logic [9:0] bullet_2_y_o,
    output logic       bullet_1_active_o,
    output logic       bullet_2_active_o,
    output logic       bullet_collide_player_1_o,
    output logic       bullet_collide_player_2_o
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } state_e;

    // Per-channel results gathered into packed vectors, channel gi at slot gi.
    logic [19:0] x_all;
    logic [19:0] y_all;
    logic [1:0]  active_all;
    logic [1:0]  hit_all;

    // run_q goes high on the first edge after reset release, so a fire key
    // already held during reset cannot launch a bullet on that first edge.
    logic run_q;

    // Reset-release qualifier for fire-edge detection.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            // Channel 0 launches just right of player 1; channel 1 just left of player 2.
            localparam logic [9:0] START_X = (gi == 0) ? 10'(P1_X + PLAYER_W) : 10'(P2_X - 1);

            state_e        state_q, state_d;
            logic [9:0]    x_q, x_d;
            logic [9:0]    y_q, y_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          fire_q;
            logic          hit_q, hit_d;

            logic          fire_w;
            logic [9:0]    owner_y;
            logic [9:0]    target_y;
            logic          fire_edge;
            logic [10:0]   x_ext;
            logic [10:0]   nx_up;
            logic [9:0]    nx_dn;
            logic          arrive;
            logic          in_y;

            assign fire_w   = (gi == 0) ? fire_1_i : fire_2_i;
            assign owner_y  = (gi == 0) ? player_1_y_i : player_2_y_i;
            assign target_y = (gi == 0) ? player_2_y_i : player_1_y_i;

            assign fire_edge = fire_w & ~fire_q & run_q;

            // 11-bit arithmetic keeps +x motion and the y window free of wrap-around;
            // the -x arrival test compares before subtracting so it never underflows.
            assign x_ext = {1'b0, x_q};
            assign nx_up = x_ext + 11'(SPEED);
            assign nx_dn = x_q - 10'(SPEED);
            assign arrive = (gi == 0)
                ? ((nx_up >= 11'(P2_X)) || (nx_up >= 11'(SCREEN_W)))
                : (x_ext < 11'(P1_X + PLAYER_W + SPEED));
            assign in_y = ({1'b0, y_q} >= {1'b0, target_y}) &&
                          ({1'b0, y_q} <= ({1'b0, target_y} + 11'(PLAYER_H - 1)));

            // Next-state logic: launch, flight and hit decision, cooldown count.
            always_comb begin
                state_d = state_q;
                x_d     = x_q;
                y_d     = y_q;
                cnt_d   = cnt_q;
                hit_d   = 1'b0;
                if (!enable_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (fire_edge) begin
                                state_d = FLY;
                                x_d     = START_X;
                                y_d     = owner_y + 10'(PLAYER_H / 2);
                            end
                        end
                        FLY: begin
                            if (frame_tick_i) begin
                                if (arrive) begin
                                    state_d = COOL;
                                    cnt_d   = '0;
                                    hit_d   = in_y;
                                end else begin
                                    x_d = (gi == 0) ? nx_up[9:0] : nx_dn;
                                end
                            end
                        end
                        COOL: begin
                            if (frame_tick_i) begin
                                if (cnt_q == CW'(COOLDOWN - 1)) begin
                                    state_d = IDLE;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CW'(1);
                                end
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            // Channel state, position, cooldown and fire-key history registers.
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    state_q <= IDLE;
                    x_q     <= '0;
                    y_q     <= '0;
                    cnt_q   <= '0;
                    fire_q  <= 1'b0;
                    hit_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    x_q     <= x_d;
                    y_q     <= y_d;
                    cnt_q   <= cnt_d;
                    fire_q  <= fire_w;
                    hit_q   <= hit_d;
                end
            end

            assign x_all[gi*10 +: 10] = x_q;
            assign y_all[gi*10 +: 10] = y_q;
            assign active_all[gi]     = (state_q == FLY);
            assign hit_all[gi]        = hit_q;
        end
    endgenerate

    assign bullet_1_x_o      = x_all[9:0];
    assign bullet_1_y_o      = y_all[9:0];
    assign bullet_2_x_o      = x_all[19:10];
    assign bullet_2_y_o      = y_all[19:10];
    assign bullet_1_active_o = active_all[0];
    assign bullet_2_active_o = active_all[1];

    // Bullet 1 hits player 2 and bullet 2 hits player 1.
    assign bullet_collide_player_2_o = hit_all[0];
    assign bullet_collide_player_1_o = hit_all[1];

endmodule

// File: doc/bullet_engine.md
BULLET_ENGINE -- requirements
Module: bullet_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, horizontal pixel count.
REQ-002 SHALL have parameter P1_X, default 32, left edge x of player 1 (left side).
REQ-003 SHALL have parameter P2_X, default 608, left edge x of player 2 (right side).
REQ-004 SHALL have parameter PLAYER_W, default 16, player width in pixels.
REQ-005 SHALL have parameter PLAYER_H, default 32, player height in pixels.
REQ-006 SHALL have parameter SPEED, default 4, bullet pixels moved per frame tick.
REQ-007 SHALL have parameter COOLDOWN, default 30, frame ticks before a player may fire again.
REQ-008 SHALL have clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have reset_ni, input, 1, asynchronous active-low reset.
REQ-010 SHALL have enable_i, input, 1, game in play (driven from is_playing_o of the game FSM).
REQ-011 SHALL have frame_tick_i, input, 1, one-cycle pulse once per video frame.
REQ-012 SHALL have fire_1_i / fire_2_i, input, 1 each, fire key levels for player 1 / player 2.
REQ-013 SHALL have player_1_y_i / player_2_y_i, input, 10 each, top-edge y of each player.
REQ-014 SHALL have bullet_1_x_o, bullet_1_y_o, bullet_2_x_o, bullet_2_y_o, output, 10 each, bullet positions for the renderer.
REQ-015 SHALL have bullet_1_active_o / bullet_2_active_o, output, 1 each, bullet visible (in FLY).
REQ-016 SHALL have bullet_collide_player_1_o / bullet_collide_player_2_o, output, 1 each, one-cycle pulse when that player is hit.

Function
REQ-017 SHALL run two independent bullet channels; bullet 1 belongs to player 1 and moves +x, bullet 2 belongs to player 2 and moves -x.
REQ-018 SHALL implement per-channel states IDLE, FLY, COOL; active_o = 1 only in FLY.
REQ-019 SHALL detect fire as a rising edge of fire_n_i using an internal registered copy; a held key SHALL NOT auto-repeat.
REQ-020 SHALL, in IDLE with enable_i=1 on a fire edge, enter FLY next cycle: bullet 1 at x=P1_X+PLAYER_W, bullet 2 at x=P2_X-1, y=owner_y+PLAYER_H/2, y latched at fire.
REQ-021 SHALL discard fire edges seen in FLY or COOL; they are not queued.
REQ-022 SHALL update positions only on cycles with frame_tick_i=1; nx = x+SPEED (bullet 1) or x-SPEED (bullet 2).
REQ-023 SHALL, for bullet 1 on a tick with nx >= P2_X, stop the bullet and go to COOL; it SHALL pulse bullet_collide_player_2_o if player_2_y_i <= y <= player_2_y_i+PLAYER_H-1, else it is a miss with no pulse.
REQ-024 SHALL, for bullet 2 on a tick with x < P1_X+PLAYER_W+SPEED, go to COOL; it SHALL pulse bullet_collide_player_1_o under the same y test against player_1_y_i (no unsigned underflow).
REQ-025 SHALL otherwise set x <= nx on the tick and stay in FLY.
REQ-026 SHALL register collide pulses: high exactly one cycle, the cycle after the deciding tick.
REQ-027 SHALL allow both collide pulses in the same cycle when both bullets hit on the same tick.
REQ-028 SHALL, in COOL, count frame ticks and return to IDLE on the COOLDOWN-th tick.
REQ-029 SHALL, when enable_i=0, force both channels to IDLE on the next edge, clear cooldown counters, and hold collide outputs 0.
REQ-030 SHALL hold x/y outputs at their last value outside FLY; the renderer gates on active_o.

Reset
REQ-031 SHALL, on reset_ni=0, immediately set both channels to IDLE with x=0, y=0, cooldown=0, fire-edge registers=0, and all outputs 0.
REQ-032 SHALL release reset synchronously to clk_i; the first fire edge is recognised no earlier than the second edge after deassertion.

Verification
REQ-033 Fire 1 edge with player_1_y_i=100, player_2_y_i=90, enable=1 -> bullet 1 FLY at (48,116), hit decided on tick 140, bullet_collide_player_2_o pulses 1 cycle, active low.
REQ-034 Fire 2 with player_2_y_i=200, player_1_y_i=300 -> bullet 2 starts x=607, decided on tick 140 as a miss, no pulse, COOL 30 ticks, then fire accepted again.
REQ-035 Fire 1 held high 200 ticks -> exactly one bullet; second fire during FLY/COOL ignored.
REQ-036 Both bullets fired same cycle, players aligned in y -> both collide pulses high in the same cycle.
REQ-037 enable_i dropped mid-flight -> active_o low next cycle, no pulse; fire immediately after re-enable accepted.
REQ-038 reset_ni asserted mid-flight, asynchronous to clk -> outputs 0 without a clock edge.
